// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V integer register file family:
// default widths, ABI register indices and the x0 test used by every port.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;

    // Widest register index supported (NREGS up to 64); narrower indices are zero-extended.
    localparam int MAX_AW = 6;
    typedef logic [MAX_AW-1:0] reg_idx_t;

    function automatic logic is_x0(input reg_idx_t addr);
        return addr == reg_idx_t'(REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file: stored value or pending
// flag, with optional same-cycle forwarding from write ports B (first) and A.
module rf_read_port
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]               rd_addr,
    input  logic                        wa_en,
    input  logic [AW-1:0]               wa_addr,
    input  logic [XLEN-1:0]             wa_data,
    input  logic                        wb_en,
    input  logic [AW-1:0]               wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            pend,
    output logic [XLEN-1:0]             rd_data,
    output logic                        rd_pend
);

    logic wa_hit;
    logic wb_hit;

    assign wb_hit = (BYPASS != 0) && wb_en && (wb_addr == rd_addr);
    assign wa_hit = (BYPASS != 0) && wa_en && (wa_addr == rd_addr);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-chain can leave it unassigned and infer a latch.
    always_comb begin
        rd_data = regs[rd_addr];
        rd_pend = pend[rd_addr];
        if (is_x0(reg_idx_t'(rd_addr))) begin
            rd_data = '0;
            rd_pend = 1'b0;
        end else if (wb_hit) begin
            rd_data = wb_data;
            rd_pend = 1'b0;
        end else if (wa_hit) begin
            rd_data = wa_data;
        end
    end

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-ported integer register file with two write ports (B over A), x0 tied
// to zero, and a per-register pending scoreboard with a running pending count.
module rv_regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_pend,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  pend_set,
    input  logic [AW-1:0]         pend_addr,
    output logic [AW:0]           pend_cnt,
    output logic                  pend_any
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           pend;
    logic [NREGS-1:0]           pend_next;
    logic [AW:0]                cnt_next;
    logic                       wa_ok;
    logic                       wb_ok;
    logic                       set_ok;
    logic                       cnt_inc;
    logic                       cnt_dec;

    assign wa_ok  = wa_en    && !is_x0(reg_idx_t'(wa_addr));
    assign wb_ok  = wb_en    && !is_x0(reg_idx_t'(wb_addr));
    assign set_ok = pend_set && !is_x0(reg_idx_t'(pend_addr));

    // Set is applied after clear so a same-address set/clear race leaves the bit pending.
    always_comb begin
        pend_next = pend;
        if (wb_ok) begin
            pend_next[wb_addr] = 1'b0;
        end
        if (set_ok) begin
            pend_next[pend_addr] = 1'b1;
        end
    end

    // Only one bit can rise and one fall per cycle, so the count moves by at most one.
    assign cnt_inc = set_ok && !pend[pend_addr];
    assign cnt_dec = wb_ok && pend[wb_addr] && !(set_ok && (pend_addr == wb_addr));

    always_comb begin
        cnt_next = pend_cnt;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_next = pend_cnt + (AW+1)'(1);
            2'b01:   cnt_next = pend_cnt - (AW+1)'(1);
            default: cnt_next = pend_cnt;
        endcase
    end

    // NOTE: the storage array is deliberately reset as a whole; software relies
    // on every architectural register reading 0 after reset, not just x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs     <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wa_ok) begin
                regs[wa_addr] <= wa_data;
            end
            // NOTE: with non-blocking assignments the later statement wins on a
            // same-address collision, which is how port B takes priority here.
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
            end
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    assign pend_any = (pend_cnt != '0);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .rd_addr (rd_addr[k*AW +: AW]),
            .wa_en   (wa_en),
            .wa_addr (wa_addr),
            .wa_data (wa_data),
            .wb_en   (wb_en),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .regs    (regs),
            .pend    (pend),
            .rd_data (rd_data[k*XLEN +: XLEN]),
            .rd_pend (rd_pend[k])
        );
    end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Scoreboard bench: a bypassing and a non-bypassing register file share one
// stimulus stream; an array model predicts every cycle's read-port view.
module tb_rv_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    typedef struct {
        logic            rst;
        logic [AW-1:0]   ra [NRD];
        logic            wa_en;
        logic [AW-1:0]   wa_addr;
        logic [XLEN-1:0] wa_data;
        logic            wb_en;
        logic [AW-1:0]   wb_addr;
        logic [XLEN-1:0] wb_data;
        logic            pend_set;
        logic [AW-1:0]   pend_addr;
    } stim_t;

    typedef struct {
        logic [XLEN-1:0] d_byp [NRD];
        logic [XLEN-1:0] d_nob [NRD];
        logic            p_byp [NRD];
        logic            p_nob [NRD];
        logic [AW:0]     cnt;
        logic            any;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data_byp, rd_data_nob;
    logic [NRD-1:0]      rd_pend_byp, rd_pend_nob;
    logic                wa_en, wb_en, pend_set;
    logic [AW-1:0]       wa_addr, wb_addr, pend_addr;
    logic [XLEN-1:0]     wa_data, wb_data;
    logic [AW:0]         pend_cnt_byp, pend_cnt_nob;
    logic                pend_any_byp, pend_any_nob;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    // Reference state: plain arrays holding the architectural view.
    logic [XLEN-1:0] m_data [NREGS];
    bit              m_pend [NREGS];

    always #5 clk = ~clk;

    rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_byp), .rd_pend(rd_pend_byp),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_cnt(pend_cnt_byp), .pend_any(pend_any_byp)
    );

    rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nob), .rd_pend(rd_pend_nob),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_cnt(pend_cnt_nob), .pend_any(pend_any_nob)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0;
        for (int k = 0; k < NRD; k++) s.ra[k] = '0;
        s.wa_en = 1'b0; s.wa_addr = '0; s.wa_data = '0;
        s.wb_en = 1'b0; s.wb_addr = '0; s.wb_data = '0;
        s.pend_set = 1'b0; s.pend_addr = '0;
        return s;
    endfunction

    // Apply one cycle: predict the combinational view, queue it, then advance the model.
    task automatic drive(input stim_t s);
        exp_t e;
        int   a;
        int   pc;
        rst = s.rst;
        for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = s.ra[k];
        wa_en = s.wa_en; wa_addr = s.wa_addr; wa_data = s.wa_data;
        wb_en = s.wb_en; wb_addr = s.wb_addr; wb_data = s.wb_data;
        pend_set = s.pend_set; pend_addr = s.pend_addr;

        for (int k = 0; k < NRD; k++) begin
            a = int'(s.ra[k]);
            if (a == 0) begin
                e.d_nob[k] = '0; e.p_nob[k] = 1'b0;
                e.d_byp[k] = '0; e.p_byp[k] = 1'b0;
            end else begin
                e.d_nob[k] = m_data[a];
                e.p_nob[k] = m_pend[a];
                e.d_byp[k] = m_data[a];
                e.p_byp[k] = m_pend[a];
                if (s.wb_en && int'(s.wb_addr) == a) begin
                    e.d_byp[k] = s.wb_data;
                    e.p_byp[k] = 1'b0;
                end else if (s.wa_en && int'(s.wa_addr) == a) begin
                    e.d_byp[k] = s.wa_data;
                end
            end
        end
        pc = 0;
        for (int r = 0; r < NREGS; r++) pc += int'(m_pend[r]);
        e.cnt = (AW+1)'(pc);
        e.any = (pc != 0);
        exp_q.push_back(e);

        if (s.rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_data[r] = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            if (s.wa_en && s.wa_addr != 0) m_data[s.wa_addr] = s.wa_data;
            if (s.wb_en && s.wb_addr != 0) m_data[s.wb_addr] = s.wb_data;
            if (s.wb_en && s.wb_addr != 0) m_pend[s.wb_addr] = 1'b0;
            if (s.pend_set && s.pend_addr != 0) m_pend[s.pend_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(1, 0) == 1) return AW'($urandom_range(7, 0));
        return AW'($urandom_range(NREGS-1, 0));
    endfunction

    // Monitor: outputs are valid every cycle, so compare one queued prediction per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("rd_data_byp[%0d]", k), 64'(rd_data_byp[k*XLEN +: XLEN]), 64'(e.d_byp[k]));
                check($sformatf("rd_pend_byp[%0d]", k), 64'(rd_pend_byp[k]), 64'(e.p_byp[k]));
                check($sformatf("rd_data_nob[%0d]", k), 64'(rd_data_nob[k*XLEN +: XLEN]), 64'(e.d_nob[k]));
                check($sformatf("rd_pend_nob[%0d]", k), 64'(rd_pend_nob[k]), 64'(e.p_nob[k]));
            end
            check("pend_cnt_byp", 64'(pend_cnt_byp), 64'(e.cnt));
            check("pend_any_byp", 64'(pend_any_byp), 64'(e.any));
            check("pend_cnt_nob", 64'(pend_cnt_nob), 64'(e.cnt));
            check("pend_any_nob", 64'(pend_any_nob), 64'(e.any));
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; rd_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        pend_set = 1'b0; pend_addr = '0;
        for (int r = 0; r < NREGS; r++) begin
            m_data[r] = '0;
            m_pend[r] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Post-reset sweep of every register on both ports.
        for (int i = 1; i < NREGS; i++) begin
            s = idle(); s.ra[0] = AW'(i); s.ra[1] = AW'(NREGS - i);
            drive(s);
        end

        // wa/wb collision on x5 with an older value already stored.
        s = idle(); s.wa_en = 1'b1; s.wa_addr = 5'd5; s.wa_data = 32'h5555_0005; s.ra[0] = 5'd5;
        drive(s);
        s = idle(); s.ra[0] = 5'd5; s.ra[1] = 5'd5;
        s.wa_en = 1'b1; s.wa_addr = 5'd5; s.wa_data = 32'h1111_1111;
        s.wb_en = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'h2222_2222;
        drive(s);
        s = idle(); s.ra[0] = 5'd5; drive(s);

        // x0 protection.
        s = idle(); s.wa_en = 1'b1; s.wa_addr = 5'd0; s.wa_data = 32'hDEAD_BEEF;
        s.pend_set = 1'b1; s.pend_addr = 5'd0;
        drive(s);
        s = idle(); drive(s);

        // Scoreboard lifecycle on x7.
        s = idle(); s.pend_set = 1'b1; s.pend_addr = 5'd7; s.ra[0] = 5'd7; drive(s);
        s = idle(); s.ra[0] = 5'd7; drive(s);
        s = idle(); s.ra[0] = 5'd7; s.wb_en = 1'b1; s.wb_addr = 5'd7; s.wb_data = 32'hABCD_0001; drive(s);
        s = idle(); s.ra[0] = 5'd7; s.ra[1] = 5'd7; drive(s);

        // Set/clear race on x9.
        s = idle(); s.pend_set = 1'b1; s.pend_addr = 5'd9; drive(s);
        s = idle(); s.ra[1] = 5'd9;
        s.pend_set = 1'b1; s.pend_addr = 5'd9; s.wb_en = 1'b1; s.wb_addr = 5'd9; s.wb_data = 32'h0909_0909;
        drive(s);
        s = idle(); s.ra[0] = 5'd9; s.ra[1] = 5'd9; drive(s);

        // Reset mid-operation with x3/x4 pending and holding data.
        s = idle(); s.pend_set = 1'b1; s.pend_addr = 5'd3; s.wa_en = 1'b1; s.wa_addr = 5'd3; s.wa_data = 32'h3333_0003;
        drive(s);
        s = idle(); s.pend_set = 1'b1; s.pend_addr = 5'd4; s.wa_en = 1'b1; s.wa_addr = 5'd4; s.wa_data = 32'h4444_0004;
        drive(s);
        s = idle(); s.ra[0] = 5'd3; s.ra[1] = 5'd4; s.rst = 1'b1;
        s.wb_en = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'hBAD0_0003;
        drive(s);
        s = idle(); s.ra[0] = 5'd3; s.ra[1] = 5'd4; drive(s);

        // Fill the scoreboard to its maximum, re-set a pending register, then drain it.
        for (int i = 1; i < NREGS; i++) begin
            s = idle(); s.pend_set = 1'b1; s.pend_addr = AW'(i); s.ra[0] = AW'(i);
            drive(s);
        end
        s = idle(); s.pend_set = 1'b1; s.pend_addr = 5'd5; s.ra[0] = 5'd5; drive(s);
        s = idle(); s.ra[1] = 5'd31; drive(s);
        for (int i = 1; i < NREGS; i++) begin
            s = idle(); s.wb_en = 1'b1; s.wb_addr = AW'(i); s.wb_data = $urandom(); s.ra[1] = AW'(i);
            drive(s);
        end

        // Randomised traffic with addresses biased towards collisions.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst = ($urandom_range(199, 0) == 0);
            for (int k = 0; k < NRD; k++) s.ra[k] = rand_addr();
            s.wa_en = ($urandom_range(1, 0) == 1);
            s.wa_addr = rand_addr(); s.wa_data = $urandom();
            s.wb_en = ($urandom_range(2, 0) == 0);
            s.wb_addr = rand_addr(); s.wb_data = $urandom();
            s.pend_set = ($urandom_range(4, 0) < 2);
            s.pend_addr = rand_addr();
            drive(s);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
